// File: rtl/custom_pio.sv
// ----------------------------------------------------------------------------
// custom_pio
//
// Avalon-MM slave peripheral that provides eight word registers. It drives the
// board LEDs, debounces the push buttons with press-edge capture and a
// maskable level interrupt, and controls a bidirectional GPIO bank with a
// direction bit per pin.
//
// Register map (word address):
//   0 LED_OUT   RW   NUM_LEDS bits, drives leds directly
//   1 BTN_STATE RO   debounced button state, 1 = pressed
//   2 BTN_EDGE  RW1C press-edge capture; a set in the same cycle beats a clear
//   3 IRQ_MASK  RW   irq = |(BTN_EDGE & IRQ_MASK)
//   4 GPIO_OUT  RW   output values for the GPIO pins
//   5 GPIO_DIR  RW   1 = pin is driven from GPIO_OUT
//   6 GPIO_IN   RO   pin levels through a 2-flop synchroniser
//   7 SCRATCH   RW   32 bits, no side effects
// Register bits above the parameter width are not stored and read as 0.
//
// Ports:
//   clk                   system clock
//   reset                 asynchronous active-low reset
//   avs_s0_address        word address
//   avs_s0_read           read strobe
//   avs_s0_write          write strobe
//   avs_s0_writedata      write data
//   avs_s0_readdata       read data, one cycle after the read strobe
//   avs_s0_readdatavalid  high for one cycle with each read response
//   irq                   level interrupt
//   button_in_port        raw asynchronous button pins
//   gpio0                 bidirectional GPIO pins
//   leds                  LED drive
//
// Bus handshake: there is no waitrequest, so every read or write strobe is
// accepted in the cycle it is presented. A write updates its register on the
// clock edge ending that cycle. A read captures the register contents as they
// are during that cycle (before any same-cycle write) and returns them in the
// next cycle with avs_s0_readdatavalid high for exactly that one cycle. Read
// and write may be presented together and act independently.
// ----------------------------------------------------------------------------
module custom_pio #(
   parameter int NUM_LEDS        = 8,
   parameter int NUM_BTNS        = 4,
   parameter int GPIO_W          = 32,
   parameter int BTN_ACTIVE_LOW  = 1,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          avs_s0_address,
   input  logic                avs_s0_read,
   input  logic                avs_s0_write,
   input  logic [31:0]         avs_s0_writedata,
   output logic [31:0]         avs_s0_readdata,
   output logic                avs_s0_readdatavalid,
   output logic                irq,
   input  logic [NUM_BTNS-1:0] button_in_port,
   inout  wire  [GPIO_W-1:0]   gpio0,
   output logic [NUM_LEDS-1:0] leds
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] A_LED_OUT   = 3'd0;
   localparam logic [2:0] A_BTN_STATE = 3'd1;
   localparam logic [2:0] A_BTN_EDGE  = 3'd2;
   localparam logic [2:0] A_IRQ_MASK  = 3'd3;
   localparam logic [2:0] A_GPIO_OUT  = 3'd4;
   localparam logic [2:0] A_GPIO_DIR  = 3'd5;
   localparam logic [2:0] A_GPIO_IN   = 3'd6;
   localparam logic [2:0] A_SCRATCH   = 3'd7;

   // Registers
   logic [NUM_LEDS-1:0] led_out;
   logic [NUM_BTNS-1:0] btn_edge;
   logic [NUM_BTNS-1:0] irq_mask;
   logic [GPIO_W-1:0]   gpio_out;
   logic [GPIO_W-1:0]   gpio_dir;
   logic [31:0]         scratch;

   // Button path state
   logic [NUM_BTNS-1:0] btn_pressed_raw;
   logic [NUM_BTNS-1:0] btn_sync1;
   logic [NUM_BTNS-1:0] btn_sync2;
   logic [NUM_BTNS-1:0] btn_stable;
   logic [CNT_W-1:0]    btn_cnt [NUM_BTNS];

   logic [NUM_BTNS-1:0] btn_stable_nxt;
   logic [CNT_W-1:0]    btn_cnt_nxt [NUM_BTNS];
   logic [NUM_BTNS-1:0] btn_rise;
   logic [NUM_BTNS-1:0] btn_w1c;
   logic [NUM_BTNS-1:0] btn_edge_nxt;

   // GPIO input synchroniser
   logic [GPIO_W-1:0]   gpio_sync1;
   logic [GPIO_W-1:0]   gpio_sync2;

   logic [31:0]         rd_mux;

   logic wr_led, wr_edge, wr_mask, wr_gout, wr_gdir, wr_scratch;

   assign wr_led     = avs_s0_write && (avs_s0_address == A_LED_OUT);
   assign wr_edge    = avs_s0_write && (avs_s0_address == A_BTN_EDGE);
   assign wr_mask    = avs_s0_write && (avs_s0_address == A_IRQ_MASK);
   assign wr_gout    = avs_s0_write && (avs_s0_address == A_GPIO_OUT);
   assign wr_gdir    = avs_s0_write && (avs_s0_address == A_GPIO_DIR);
   assign wr_scratch = avs_s0_write && (avs_s0_address == A_SCRATCH);

   // The polarity inversion is applied ahead of the synchroniser rather than
   // after it. Inversion commutes with the flops, and this way the all-zero
   // reset state of the synchroniser already means "released", so the
   // debouncer sees no phantom press right after reset.
   assign btn_pressed_raw = (BTN_ACTIVE_LOW != 0) ? ~button_in_port : button_in_port;

   // Debounce: the counter runs while the synchronised level disagrees with
   // the accepted state and the new level is accepted once it has disagreed
   // for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      btn_stable_nxt = btn_stable;
      for (int i = 0; i < NUM_BTNS; i++) begin
         btn_cnt_nxt[i] = '0;
         if (btn_sync2[i] != btn_stable[i]) begin
            if (btn_cnt[i] == CNT_LAST) begin
               btn_stable_nxt[i] = btn_sync2[i];
            end else begin
               btn_cnt_nxt[i] = btn_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Presses only; a set in the same cycle as a W1C of that bit wins.
   assign btn_rise     = btn_stable_nxt & ~btn_stable;
   assign btn_w1c      = wr_edge ? avs_s0_writedata[NUM_BTNS-1:0] : '0;
   assign btn_edge_nxt = (btn_edge & ~btn_w1c) | btn_rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_sync1  <= '0;
         btn_sync2  <= '0;
         btn_stable <= '0;
         btn_edge   <= '0;
         for (int i = 0; i < NUM_BTNS; i++) begin
            btn_cnt[i] <= '0;
         end
      end else begin
         btn_sync1  <= btn_pressed_raw;
         btn_sync2  <= btn_sync1;
         btn_stable <= btn_stable_nxt;
         btn_edge   <= btn_edge_nxt;
         for (int i = 0; i < NUM_BTNS; i++) begin
            btn_cnt[i] <= btn_cnt_nxt[i];
         end
      end
   end

   // Plain read/write registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_out  <= '0;
         irq_mask <= '0;
         gpio_out <= '0;
         gpio_dir <= '0;
         scratch  <= '0;
      end else begin
         if (wr_led)     led_out  <= avs_s0_writedata[NUM_LEDS-1:0];
         if (wr_mask)    irq_mask <= avs_s0_writedata[NUM_BTNS-1:0];
         if (wr_gout)    gpio_out <= avs_s0_writedata[GPIO_W-1:0];
         if (wr_gdir)    gpio_dir <= avs_s0_writedata[GPIO_W-1:0];
         if (wr_scratch) scratch  <= avs_s0_writedata;
      end
   end

   // GPIO pins: driven only where the direction bit is set
   for (genvar g = 0; g < GPIO_W; g++) begin : g_gpio
      assign gpio0[g] = gpio_dir[g] ? gpio_out[g] : 1'bz;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gpio_sync1 <= '0;
         gpio_sync2 <= '0;
      end else begin
         gpio_sync1 <= gpio0;
         gpio_sync2 <= gpio_sync1;
      end
   end

   // Read mux sees register contents before any same-cycle write lands.
   always_comb begin
      rd_mux = '0;
      case (avs_s0_address)
         A_LED_OUT:   rd_mux = 32'(led_out);
         A_BTN_STATE: rd_mux = 32'(btn_stable);
         A_BTN_EDGE:  rd_mux = 32'(btn_edge);
         A_IRQ_MASK:  rd_mux = 32'(irq_mask);
         A_GPIO_OUT:  rd_mux = 32'(gpio_out);
         A_GPIO_DIR:  rd_mux = 32'(gpio_dir);
         A_GPIO_IN:   rd_mux = 32'(gpio_sync2);
         A_SCRATCH:   rd_mux = scratch;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         avs_s0_readdata      <= '0;
         avs_s0_readdatavalid <= 1'b0;
      end else begin
         avs_s0_readdatavalid <= avs_s0_read;
         if (avs_s0_read) avs_s0_readdata <= rd_mux;
      end
   end

   assign leds = led_out;
   assign irq  = |(btn_edge & irq_mask);

endmodule

// File: tb/tb_custom_pio.sv
// ----------------------------------------------------------------------------
// tb_custom_pio
//
// Directed bench for custom_pio with DEBOUNCE_CYCLES = 4. Read requests push
// their expected data into exp_q; a monitor on the falling edge pops and
// compares whenever readdatavalid is high. Level outputs (leds, irq, pins)
// are compared directly after each step.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_custom_pio;

   logic        clk;
   logic        reset;
   logic [2:0]  avs_s0_address;
   logic        avs_s0_read;
   logic        avs_s0_write;
   logic [31:0] avs_s0_writedata;
   logic [31:0] avs_s0_readdata;
   logic        avs_s0_readdatavalid;
   logic        irq;
   logic [3:0]  btn_raw;
   wire  [31:0] gpio_pins;
   logic [7:0]  leds;

   // External pin model: per-bit drive enable and value
   logic [31:0] ext_en;
   logic [31:0] ext_val;

   for (genvar g = 0; g < 32; g++) begin : g_ext
      assign gpio_pins[g] = ext_en[g] ? ext_val[g] : 1'bz;
   end

   logic [31:0] exp_q[$];
   int          chk_cnt = 0;
   int          err_cnt = 0;

   custom_pio #(
      .NUM_LEDS        (8),
      .NUM_BTNS        (4),
      .GPIO_W          (32),
      .BTN_ACTIVE_LOW  (1),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .avs_s0_address       (avs_s0_address),
      .avs_s0_read          (avs_s0_read),
      .avs_s0_write         (avs_s0_write),
      .avs_s0_writedata     (avs_s0_writedata),
      .avs_s0_readdata      (avs_s0_readdata),
      .avs_s0_readdatavalid (avs_s0_readdatavalid),
      .irq                  (irq),
      .button_in_port       (btn_raw),
      .gpio0                (gpio_pins),
      .leds                 (leds)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (avs_s0_readdatavalid) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL rdv_spurious: got readdatavalid=1 expected 0 at %0t", $time);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("readdata", avs_s0_readdata, e);
         end
      end
   end

   // ---------------- drivers (called at posedge+1) ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      avs_s0_address   = a;
      avs_s0_writedata = d;
      avs_s0_write     = 1'b1;
      @(posedge clk);
      #1;
      avs_s0_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
      avs_s0_address = a;
      avs_s0_read    = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      avs_s0_read    = 1'b0;
   endtask

   task automatic bus_rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp);
      avs_s0_address   = a;
      avs_s0_writedata = d;
      avs_s0_read      = 1'b1;
      avs_s0_write     = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      avs_s0_read      = 1'b0;
      avs_s0_write     = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset            = 1'b0;
      avs_s0_address   = '0;
      avs_s0_read      = 1'b0;
      avs_s0_write     = 1'b0;
      avs_s0_writedata = '0;
      btn_raw          = 4'hF;
      ext_en           = '0;
      ext_val          = '0;

      // Reset state
      #2;
      check("rst_leds", 32'(leds), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_rdv", 32'(avs_s0_readdatavalid), 32'h0);
      check("rst_readdata", avs_s0_readdata, 32'h0);
      ext_en  = 32'hFFFF_FFFF;
      ext_val = 32'hC3C3_3C3C;
      #1;
      check("rst_pins_undriven", gpio_pins, 32'hC3C3_3C3C);
      ext_val = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      idle(2);

      // Register map after reset
      for (int a = 0; a < 8; a++) bus_read(3'(a), 32'h0);

      // LED register, width truncation
      bus_write(3'd0, 32'hFFFF_FFFF);
      check("leds_all", 32'(leds), 32'h0000_00FF);
      bus_read(3'd0, 32'h0000_00FF);
      bus_write(3'd0, 32'h0000_015A);
      check("leds_5a", 32'(leds), 32'h0000_005A);

      // Scratch and same-cycle read/write
      bus_write(3'd7, 32'h1111_1111);
      bus_rw(3'd7, 32'h2222_2222, 32'h1111_1111);
      bus_read(3'd7, 32'h2222_2222);

      // IRQ_MASK width, then cleared
      bus_write(3'd3, 32'hFFFF_FFFF);
      bus_read(3'd3, 32'h0000_000F);
      bus_write(3'd3, 32'h0);

      // Glitch of 3 cycles on btn[1] is rejected
      btn_raw[1] = 1'b0;
      idle(3);
      btn_raw[1] = 1'b1;
      idle(8);
      bus_read(3'd1, 32'h0);
      bus_read(3'd2, 32'h0);

      // Held press accepted exactly 6 cycles after the pin change
      btn_raw[1] = 1'b0;
      idle(5);
      bus_read(3'd1, 32'h0);      // sampled in the cycle before acceptance
      bus_read(3'd1, 32'h2);
      bus_read(3'd2, 32'h2);
      check("irq_masked", 32'(irq), 32'h0);

      // Interrupt enable and W1C
      bus_write(3'd3, 32'h2);
      check("irq_rise", 32'(irq), 32'h1);
      bus_write(3'd2, 32'h2);
      check("irq_fall", 32'(irq), 32'h0);
      bus_read(3'd2, 32'h0);

      // Release is not captured
      btn_raw[1] = 1'b1;
      idle(8);
      bus_read(3'd1, 32'h0);
      bus_read(3'd2, 32'h0);

      // Collision: W1C of bit 0 in the cycle its press is accepted
      bus_write(3'd3, 32'h3);
      btn_raw[0] = 1'b0;
      idle(5);
      bus_write(3'd2, 32'h1);
      check("collision_irq", 32'(irq), 32'h1);
      bus_read(3'd2, 32'h1);
      bus_write(3'd1, 32'hFFFF_FFFF);   // read-only, ignored
      bus_read(3'd1, 32'h1);

      // GPIO
      ext_en  = 32'hFFFF_FF00;
      ext_val = 32'h1234_0000;
      bus_write(3'd5, 32'h0000_00FF);
      bus_write(3'd4, 32'hA5A5_A5A5);
      check("gpio_pins", gpio_pins, 32'h1234_00A5);
      idle(2);
      bus_read(3'd6, 32'h1234_00A5);
      bus_write(3'd6, 32'hFFFF_FFFF);   // read-only, ignored
      bus_read(3'd6, 32'h1234_00A5);
      bus_read(3'd4, 32'hA5A5_A5A5);
      bus_read(3'd5, 32'h0000_00FF);
      check("irq_before_reset", 32'(irq), 32'h1);

      // Async reset mid-debounce (btn[0] release counter at 2) and mid-read
      btn_raw[0] = 1'b1;
      idle(3);
      bus_read(3'd0, 32'h0000_005A);    // response is pending when reset hits
      reset = 1'b0;
      #1;
      exp_q.delete();
      ext_en  = 32'hFFFF_FFFF;
      ext_val = 32'h0F0F_0F0F;
      #1;
      check("mid_rst_pins", gpio_pins, 32'h0F0F_0F0F);
      check("mid_rst_leds", 32'(leds), 32'h0);
      check("mid_rst_irq", 32'(irq), 32'h0);
      check("mid_rst_rdv", 32'(avs_s0_readdatavalid), 32'h0);
      check("mid_rst_readdata", avs_s0_readdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b1;
      ext_val = '0;
      idle(8);
      check("post_rst_irq", 32'(irq), 32'h0);
      bus_read(3'd2, 32'h0);
      bus_read(3'd1, 32'h0);
      bus_read(3'd5, 32'h0);
      bus_read(3'd0, 32'h0);

      // Every issued read must have been answered
      idle(3);
      check("responses_outstanding", 32'(exp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
